// File: rtl/player_motion_pkg.sv
// Shared definitions for the player motion block and the key decoder.
// Holds the movement command codes, the motion state encoding, the width
// of the hang/crouch duration counter and a small state-classification
// helper.
package player_motion_pkg;

  // Movement command codes produced by the key decoder.
  localparam logic [2:0] MOVE_NONE       = 3'b000;
  localparam logic [2:0] MOVE_BIG_JUMP   = 3'b001;
  localparam logic [2:0] MOVE_SMALL_JUMP = 3'b010;
  localparam logic [2:0] MOVE_CROUCH     = 3'b011;
  localparam logic [2:0] MOVE_DROP       = 3'b100;

  // Width of the hang/crouch down-counter.
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RISE   = 3'd1,
    ST_HANG   = 3'd2,
    ST_FALL   = 3'd3,
    ST_DROP   = 3'd4,
    ST_CROUCH = 3'd5
  } state_e;

  // True for every state in which the player is off the ground.
  function automatic logic is_airborne(input state_e s);
    return (s == ST_RISE) || (s == ST_HANG) || (s == ST_FALL) || (s == ST_DROP);
  endfunction

endpackage

// File: rtl/player_motion_duration_counter.sv
// duration_counter: loadable down-counter used for the apex hang and the
// crouch duration.
// Ports:
//   clk, reset   - clock, synchronous active-high reset (clears count)
//   load         - load load_value (has priority over dec)
//   load_value   - value loaded on load
//   dec          - decrement by one, saturating at zero
//   count        - current counter value
//   zero         - count equals zero
module duration_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Counter register: load wins over decrement; decrement never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {W{1'b0}};
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != {W{1'b0}})) begin
      count <= count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign zero = (count == {W{1'b0}});

endmodule

// File: rtl/player_motion.sv
// player_motion: vertical motion of the player sprite. Turns one-cycle
// movement commands into a jump arc (rise, hang at apex, fall), a fast
// drop, or a timed crouch, stepping position once per tick.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   tick       - one-cycle frame-step enable
//   movement   - one-cycle command pulse (codes in player_motion_pkg)
//   player_y   - height above ground in pixels
//   airborne   - high in RISE, HANG, FALL, DROP
//   crouching  - high in CROUCH
//   landed     - one-clk pulse on return to ground from FALL or DROP
//   busy       - high whenever not IDLE
module player_motion #(
  parameter int BIG_H        = 24,
  parameter int SMALL_H      = 12,
  parameter int HANG_TICKS   = 4,
  parameter int CROUCH_TICKS = 16,
  parameter int Y_W          = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic [2:0]     movement,
  output logic [Y_W-1:0] player_y,
  output logic           airborne,
  output logic           crouching,
  output logic           landed,
  output logic           busy
);

  import player_motion_pkg::*;

  state_e             state;
  state_e             next_state;
  logic [Y_W-1:0]     next_y;
  logic [Y_W-1:0]     target;
  logic [Y_W-1:0]     next_target;
  logic [Y_W-1:0]     y_up;
  logic [Y_W-1:0]     y_down;
  logic [Y_W-1:0]     y_drop;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_value;
  logic               cnt_dec;
  logic [CNT_W-1:0]   cnt_count;
  logic               cnt_zero;
  logic               cnt_last;
  logic               next_airborne;
  logic               next_crouching;
  logic               next_landed;
  logic               next_busy;

  assign y_up   = player_y + {{(Y_W-1){1'b0}}, 1'b1};
  assign y_down = player_y - {{(Y_W-1){1'b0}}, 1'b1};
  // Drop steps two pixels but saturates at ground instead of wrapping.
  assign y_drop = (player_y <= Y_W'(2)) ? {Y_W{1'b0}} : (player_y - Y_W'(2));
  // This tick brings the counter to zero (or it is already there).
  assign cnt_last = cnt_zero || (cnt_count == CNT_W'(1));

  duration_counter #(.W(CNT_W)) u_duration (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .dec        (cnt_dec),
    .count      (cnt_count),
    .zero       (cnt_zero)
  );

  // State, position and jump-target registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      player_y <= {Y_W{1'b0}};
      target   <= {Y_W{1'b0}};
    end else begin
      state    <= next_state;
      player_y <= next_y;
      target   <= next_target;
    end
  end

  // Next-state logic. A command accepted in a cycle takes precedence over a
  // tick in that same cycle; the position step waits for the following tick.
  always_comb begin
    next_state  = state;
    next_y      = player_y;
    next_target = target;
    cnt_load    = 1'b0;
    cnt_value   = {CNT_W{1'b0}};
    cnt_dec     = 1'b0;
    case (state)
      ST_IDLE: begin
        case (movement)
          MOVE_BIG_JUMP: begin
            next_state  = ST_RISE;
            next_target = Y_W'(BIG_H);
          end
          MOVE_SMALL_JUMP: begin
            next_state  = ST_RISE;
            next_target = Y_W'(SMALL_H);
          end
          MOVE_CROUCH: begin
            next_state = ST_CROUCH;
            cnt_load   = 1'b1;
            cnt_value  = CNT_W'(CROUCH_TICKS);
          end
          default: next_state = ST_IDLE;
        endcase
      end
      ST_RISE: begin
        if (movement == MOVE_DROP) begin
          next_state = ST_DROP;
        end else if (tick) begin
          next_y = y_up;
          if (y_up == target) begin
            next_state = ST_HANG;
            cnt_load   = 1'b1;
            cnt_value  = CNT_W'(HANG_TICKS);
          end else begin
            next_state = ST_RISE;
          end
        end else begin
          next_state = ST_RISE;
        end
      end
      ST_HANG: begin
        if (movement == MOVE_DROP) begin
          next_state = ST_DROP;
        end else if (tick) begin
          cnt_dec    = 1'b1;
          next_state = cnt_last ? ST_FALL : ST_HANG;
        end else begin
          next_state = ST_HANG;
        end
      end
      ST_FALL: begin
        if (movement == MOVE_DROP) begin
          next_state = ST_DROP;
        end else if (tick) begin
          next_y     = y_down;
          next_state = (y_down == {Y_W{1'b0}}) ? ST_IDLE : ST_FALL;
        end else begin
          next_state = ST_FALL;
        end
      end
      ST_DROP: begin
        if (tick) begin
          next_y     = y_drop;
          next_state = (y_drop == {Y_W{1'b0}}) ? ST_IDLE : ST_DROP;
        end else begin
          next_state = ST_DROP;
        end
      end
      ST_CROUCH: begin
        if (tick) begin
          cnt_dec    = 1'b1;
          next_state = cnt_last ? ST_IDLE : ST_CROUCH;
        end else begin
          next_state = ST_CROUCH;
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_y     = {Y_W{1'b0}};
      end
    endcase
  end

  // Output decode from the upcoming state so the flags can be registered
  // and still line up with the state they describe.
  always_comb begin
    next_airborne  = is_airborne(next_state);
    next_crouching = (next_state == ST_CROUCH);
    next_busy      = (next_state != ST_IDLE);
    next_landed    = ((state == ST_FALL) || (state == ST_DROP)) && (next_state == ST_IDLE);
  end

  // Registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      airborne  <= 1'b0;
      crouching <= 1'b0;
      landed    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      airborne  <= next_airborne;
      crouching <= next_crouching;
      landed    <= next_landed;
      busy      <= next_busy;
    end
  end

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: directed scenarios with fixed
// expected trajectories, then randomized traffic against a behavioural
// model that tracks the jump as elapsed ticks along an arc.
module tb_player_motion;

  localparam int BIG_H        = 24;
  localparam int SMALL_H      = 12;
  localparam int HANG_TICKS   = 4;
  localparam int CROUCH_TICKS = 16;
  localparam int Y_W          = 7;

  logic           clk = 1'b0;
  logic           reset;
  logic           tick;
  logic [2:0]     movement;
  logic [Y_W-1:0] player_y;
  logic           airborne;
  logic           crouching;
  logic           landed;
  logic           busy;

  int total = 0;
  int bad   = 0;

  // model: mode 0 ground, 1 jumping, 2 dropping, 3 crouching
  int m_mode, m_y, m_h, m_t, m_rem, m_land;

  player_motion #(
    .BIG_H(BIG_H), .SMALL_H(SMALL_H), .HANG_TICKS(HANG_TICKS),
    .CROUCH_TICKS(CROUCH_TICKS), .Y_W(Y_W)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .movement(movement),
    .player_y(player_y), .airborne(airborne), .crouching(crouching),
    .landed(landed), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Height along a jump arc of apex h after t ticks.
  function automatic int air_pos(input int t, input int h);
    if (t <= h) return t;
    else if (t <= h + HANG_TICKS) return h;
    else return 2 * h + HANG_TICKS - t;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_y = 0; m_h = 0; m_t = 0; m_rem = 0; m_land = 0;
  endtask

  task automatic model_step(input logic t, input logic [2:0] m);
    m_land = 0;
    case (m_mode)
      0: begin
        if (m == 3'd1) begin m_mode = 1; m_h = BIG_H; m_t = 0; end
        else if (m == 3'd2) begin m_mode = 1; m_h = SMALL_H; m_t = 0; end
        else if (m == 3'd3) begin m_mode = 3; m_rem = CROUCH_TICKS; end
      end
      1: begin
        if (m == 3'd4) m_mode = 2;
        else if (t) begin
          m_t++;
          m_y = air_pos(m_t, m_h);
          if (m_t == 2 * m_h + HANG_TICKS) begin m_mode = 0; m_land = 1; end
        end
      end
      2: begin
        if (t) begin
          m_y = (m_y > 2) ? m_y - 2 : 0;
          if (m_y == 0) begin m_mode = 0; m_land = 1; end
        end
      end
      default: begin
        if (t) begin
          m_rem--;
          if (m_rem == 0) m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic cycle(input logic t, input logic [2:0] m);
    tick = t; movement = m;
    @(posedge clk);
    model_step(t, m);
    #1;
    tick = 1'b0; movement = 3'd0;
  endtask

  task automatic do_reset(input logic t, input logic [2:0] m);
    reset = 1'b1; tick = t; movement = m;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0; tick = 1'b0; movement = 3'd0;
  endtask

  task automatic test_reset();
    do_reset(1'b1, 3'd1);
    total++; if (player_y !== 7'd0) begin bad++; $display("FAIL reset_y got=%0d exp=0", player_y); end
    total++; if (airborne !== 1'b0) begin bad++; $display("FAIL reset_airborne got=%b exp=0", airborne); end
    total++; if (crouching !== 1'b0) begin bad++; $display("FAIL reset_crouching got=%b exp=0", crouching); end
    total++; if (landed !== 1'b0) begin bad++; $display("FAIL reset_landed got=%b exp=0", landed); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_big_jump();
    int lands = 0, ybad = 0, airbad = 0;
    cycle(1'b1, 3'd1);  // command and tick together: no step yet
    total++; if (player_y !== 7'd0 || airborne !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL big_start y=%0d air=%b busy=%b exp y=0 air=1 busy=1", player_y, airborne, busy);
    end
    for (int i = 1; i <= 2 * BIG_H + HANG_TICKS; i++) begin
      cycle(1'b1, 3'd0);
      if (player_y !== Y_W'(air_pos(i, BIG_H))) ybad++;
      if (landed) lands++;
      if (i < 2 * BIG_H + HANG_TICKS && airborne !== 1'b1) airbad++;
    end
    total++; if (ybad != 0) begin bad++; $display("FAIL big_traj wrong_y_ticks=%0d exp=0", ybad); end
    total++; if (airbad != 0) begin bad++; $display("FAIL big_airborne low_ticks=%0d exp=0", airbad); end
    total++; if (landed !== 1'b1 || airborne !== 1'b0) begin
      bad++; $display("FAIL big_land landed=%b air=%b exp landed=1 air=0", landed, airborne);
    end
    cycle(1'b0, 3'd0);
    total++; if (lands != 1 || landed !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL big_land_pulse count=%0d landed=%b busy=%b exp 1,0,0", lands, landed, busy);
    end
  endtask

  task automatic test_small_jump();
    int ybad = 0;
    cycle(1'b0, 3'd2);
    for (int i = 1; i <= 2 * SMALL_H + HANG_TICKS; i++) begin
      cycle(1'b1, 3'd0);
      if (player_y !== Y_W'(air_pos(i, SMALL_H))) ybad++;
      if (i == SMALL_H) begin
        cycle(1'b0, 3'd1);  // big jump at apex must be ignored
        total++; if (player_y !== Y_W'(SMALL_H) || airborne !== 1'b1) begin
          bad++; $display("FAIL small_apex y=%0d air=%b exp y=%0d air=1", player_y, airborne, SMALL_H);
        end
      end
    end
    total++; if (ybad != 0) begin bad++; $display("FAIL small_traj wrong_y_ticks=%0d exp=0", ybad); end
    total++; if (landed !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL small_land landed=%b busy=%b exp 1,0", landed, busy);
    end
    cycle(1'b0, 3'd0);
  endtask

  task automatic test_drop(input int start, input int n_exp);
    int seq [$];
    int y = start;
    while (y > 0) begin y = (y > 2) ? y - 2 : 0; seq.push_back(y); end
    cycle(1'b0, 3'd1);
    for (int i = 0; i < start; i++) cycle(1'b1, 3'd0);
    cycle(1'b0, 3'd4);
    total++; if (player_y !== Y_W'(start) || airborne !== 1'b1) begin
      bad++; $display("FAIL drop_accept y=%0d air=%b exp y=%0d air=1", player_y, airborne, start);
    end
    total++; if (seq.size() != n_exp) begin bad++; $display("FAIL drop_len got=%0d exp=%0d", seq.size(), n_exp); end
    foreach (seq[k]) begin
      cycle(1'b1, 3'd0);
      total++; if (player_y !== Y_W'(seq[k])) begin
        bad++; $display("FAIL drop_step%0d got=%0d exp=%0d", k, player_y, seq[k]);
      end
    end
    total++; if (landed !== 1'b1 || airborne !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL drop_land landed=%b air=%b busy=%b exp 1,0,0", landed, airborne, busy);
    end
    cycle(1'b0, 3'd0);
  endtask

  task automatic test_crouch();
    int n = 0, lands = 0, busybad = 0;
    cycle(1'b0, 3'd3);
    total++; if (crouching !== 1'b1 || busy !== 1'b1 || player_y !== 7'd0) begin
      bad++; $display("FAIL crouch_start cr=%b busy=%b y=%0d exp 1,1,0", crouching, busy, player_y);
    end
    for (int i = 0; i < 40 && crouching; i++) begin
      n++;
      cycle(1'b1, 3'd0);
      if (landed) lands++;
      if (busy !== crouching) busybad++;
      if (n == 8) begin
        cycle(1'b0, 3'd1);
        total++; if (crouching !== 1'b1 || airborne !== 1'b0) begin
          bad++; $display("FAIL crouch_ignore cr=%b air=%b exp 1,0", crouching, airborne);
        end
      end
    end
    total++; if (n != CROUCH_TICKS) begin bad++; $display("FAIL crouch_len got=%0d exp=%0d", n, CROUCH_TICKS); end
    total++; if (lands != 0 || busybad != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL crouch_exit lands=%0d busy_mismatch=%0d busy=%b exp 0,0,0", lands, busybad, busy);
    end
  endtask

  task automatic test_reset_mid_fall();
    cycle(1'b0, 3'd1);
    for (int i = 0; i < 2 * BIG_H + HANG_TICKS - 17; i++) cycle(1'b1, 3'd0);
    total++; if (player_y !== 7'd17) begin bad++; $display("FAIL mid_fall_y got=%0d exp=17", player_y); end
    do_reset(1'b1, 3'd4);
    total++; if ({player_y, airborne, crouching, landed, busy} !== 11'd0) begin
      bad++; $display("FAIL mid_reset y=%0d air=%b cr=%b land=%b busy=%b exp all 0",
                      player_y, airborne, crouching, landed, busy);
    end
    cycle(1'b0, 3'd2);
    total++; if (landed !== 1'b0 || airborne !== 1'b1) begin
      bad++; $display("FAIL post_reset_jump landed=%b air=%b exp 0,1", landed, airborne);
    end
    for (int i = 0; i < SMALL_H; i++) cycle(1'b1, 3'd0);
    total++; if (player_y !== Y_W'(SMALL_H)) begin bad++; $display("FAIL post_reset_apex got=%0d exp=%0d", player_y, SMALL_H); end
    for (int i = 0; i < SMALL_H + HANG_TICKS; i++) cycle(1'b1, 3'd0);
    cycle(1'b0, 3'd0);
  endtask

  task automatic test_random();
    logic t;
    logic [2:0] m;
    for (int c = 0; c < 4000; c++) begin
      t = ($urandom_range(0, 1) == 1);
      m = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      if ($urandom_range(0, 599) == 0) do_reset(t, m);
      else cycle(t, m);
      total++;
      if ({player_y, airborne, crouching, landed, busy} !==
          {Y_W'(m_y), (m_mode == 1 || m_mode == 2), (m_mode == 3), (m_land == 1), (m_mode != 0)}) begin
        bad++;
        $display("FAIL random c=%0d got y=%0d air=%b cr=%b land=%b busy=%b exp y=%0d mode=%0d land=%0d",
                 c, player_y, airborne, crouching, landed, busy, m_y, m_mode, m_land);
      end
    end
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; movement = 3'd0;
    model_reset();
    test_reset();
    test_big_jump();
    test_small_jump();
    test_drop(10, 5);
    test_drop(5, 3);
    test_crouch();
    test_reset_mid_fall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/player_motion.md
PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 SHALL have parameter BIG_H, default 24, big-jump apex height in pixels.
REQ-002 SHALL have parameter SMALL_H, default 12, small-jump apex height in pixels.
REQ-003 SHALL have parameter HANG_TICKS, default 4, number of ticks held at the apex.
REQ-004 SHALL have parameter CROUCH_TICKS, default 16, crouch duration in ticks.
REQ-005 SHALL have parameter Y_W, default 7, width of player_y.
REQ-006 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high; clock clk.
REQ-008 SHALL have port tick  input  1  one-cycle frame-step enable.
REQ-009 SHALL have port movement  input  3  one-cycle command pulse from the key decoder.
REQ-010 SHALL have port player_y  output  Y_W  height above ground in pixels.
REQ-011 SHALL have port airborne  output  1  high in RISE, HANG, FALL and DROP.
REQ-012 SHALL have port crouching  output  1  high in CROUCH.
REQ-013 SHALL have port landed  output  1  one-clk pulse on return to ground.
REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL decode movement as: 000 none; 001 big jump; 010 small jump; 011 crouch; 100 drop; 101-111 ignored.
REQ-016 SHALL sample movement every clk; an accepted command changes state at the next edge, independent of tick.
REQ-017 SHALL implement states IDLE, RISE, HANG, FALL, DROP, CROUCH.
REQ-018 IDLE: 001 loads target=BIG_H and goes to RISE; 010 loads target=SMALL_H and goes to RISE; 011 loads the counter with CROUCH_TICKS and goes to CROUCH; 100 is ignored.
REQ-019 RISE: each tick increments player_y by 1; on the tick where player_y+1==target, go to HANG and load the counter with HANG_TICKS.
REQ-020 HANG: player_y is held; each tick decrements the counter; on the tick where the counter reaches 0, go to FALL.
REQ-021 FALL: each tick decrements player_y by 1; on the tick where player_y becomes 0, go to IDLE.
REQ-022 DROP: each tick sets player_y to player_y-2, saturating at 0; on the tick where player_y becomes 0, go to IDLE.
REQ-023 A 100 command SHALL be accepted in RISE, HANG and FALL and go to DROP; DROP takes effect on the next tick.
REQ-024 Jump and crouch commands SHALL be ignored in every state except IDLE; any command in CROUCH or DROP SHALL be ignored.
REQ-025 CROUCH: player_y stays 0; each tick decrements the counter; on reaching 0, go to IDLE; crouching is high for exactly CROUCH_TICKS ticks.
REQ-026 A command and a tick in the same IDLE cycle: the transition wins and the first position step occurs on the next tick.
REQ-027 landed SHALL be high for exactly one clk, in the first cycle of IDLE entered from FALL or DROP; it SHALL NOT pulse on exit from CROUCH.
REQ-028 All outputs SHALL be registered; player_y SHALL never exceed BIG_H and never wrap below 0.
REQ-029 Total big-jump air time SHALL be 2*BIG_H+HANG_TICKS ticks (52 at default); small jump 2*SMALL_H+HANG_TICKS ticks (28 at default).

Reset
REQ-030 Reset SHALL dominate tick and movement.
REQ-031 On reset: state IDLE, player_y=0, airborne=0, crouching=0, landed=0, busy=0, counter=0, target=0.
REQ-032 Reset asserted mid-jump or mid-crouch SHALL return to ground immediately without a landed pulse.

Structure
REQ-033 Movement code constants (MOVE_NONE, MOVE_BIG_JUMP, MOVE_SMALL_JUMP, MOVE_CROUCH, MOVE_DROP) and the state encoding SHALL live in a shared package used by the decoder and this block.
REQ-034 The hang/crouch down-counter SHALL be one sub-module, duration_counter (load, tick-decrement, zero flag).

Verification
REQ-035 Big jump: pulse 001, then 52 ticks -> player_y rises 0..24, holds 24 for 4 ticks, falls to 0; landed pulses once.
REQ-036 Small jump: pulse 010 -> apex 12; 28 ticks total; 001 pulsed at apex is ignored.
REQ-037 Drop: 001, then 10 ticks (player_y=10), then 100 -> player_y goes 8,6,4,2,0 over 5 ticks; landed=1.
REQ-038 Odd drop: drop at player_y=5 -> 3,1,0; no underflow.
REQ-039 Crouch: 011 -> crouching=1 for 16 ticks; 001 issued during crouch is ignored; busy falls with crouching; no landed pulse.
REQ-040 Reset at player_y=17 during FALL -> next edge all outputs 0; no landed pulse; a new 010 is then accepted normally.
